// File: rtl/rf_wb_if.sv
// Writeback bus between the ALU/load sources, the arbiter and the register file.
// Bypass taps are present only when RF_WB_ARB_BYPASS_EN is defined.
interface rf_wb_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            alu_prio;
`ifdef RF_WB_ARB_BYPASS_EN
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_fwd_hit;
    logic            rs2_fwd_hit;
    logic [XLEN-1:0] fwd_data;
`endif

    // master: sources, register file and decode taps; slave: the arbiter
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
`ifdef RF_WB_ARB_BYPASS_EN
        output rs1_addr, rs2_addr,
        input  rs1_fwd_hit, rs2_fwd_hit, fwd_data,
`endif
        input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, alu_prio
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
`ifdef RF_WB_ARB_BYPASS_EN
        input  rs1_addr, rs2_addr,
        output rs1_fwd_hit, rs2_fwd_hit, fwd_data,
`endif
        output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, alu_prio
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: loads win by default, starved ALU writes get forced through.
// Optional decode bypass taps under RF_WB_ARB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4   // 1..15
) (
    input  logic    clk,
    input  logic    rst,
    rf_wb_if.slave  bus
);
    typedef enum logic {PRI_MEM = 1'b0, PRI_ALU = 1'b1} state_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          state, state_nxt;
    logic [3:0]      starve_cnt, starve_cnt_nxt;
    logic            alu_gnt, mem_gnt, xfer;
    wb_req_t         win;
    logic [1:0]      vld_pipe;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;

    // Combinational grant; nothing is accepted while reset is held.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (state == PRI_MEM) begin
                mem_gnt = bus.mem_valid;
                alu_gnt = bus.alu_valid & ~bus.mem_valid;
            end else begin
                alu_gnt = bus.alu_valid;
                mem_gnt = bus.mem_valid & ~bus.alu_valid;
            end
        end
    end

    always_comb begin
        win = '{rd: bus.alu_rd, data: bus.alu_data};
        if (mem_gnt) win = '{rd: bus.mem_rd, data: bus.mem_data};
    end

    assign xfer        = alu_gnt | mem_gnt;
    // x0 writes are accepted but never reach the register file
    assign vld_pipe[0] = xfer & (win.rd != 5'd0);

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        if (!bus.alu_valid || alu_gnt)
            starve_cnt_nxt = 4'd0;
        else if (mem_gnt && starve_cnt != LIMIT)
            starve_cnt_nxt = starve_cnt + 4'd1;
        case (state)
            PRI_MEM: if (starve_cnt_nxt == LIMIT) state_nxt = PRI_ALU;
            PRI_ALU: if (alu_gnt || !bus.alu_valid) state_nxt = PRI_MEM;
            default: state_nxt = PRI_MEM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PRI_MEM;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // One-cycle output stage; addr/data hold when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                waddr_q <= win.rd;
                wdata_q <= win.data;
            end
        end
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.mem_ready = mem_gnt;
    assign bus.rf_we     = vld_pipe[1];
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.alu_prio  = (state == PRI_ALU);

`ifdef RF_WB_ARB_BYPASS_EN
    // Lets decode see a write that the register file has not committed yet.
    assign bus.rs1_fwd_hit = vld_pipe[1] & (waddr_q == bus.rs1_addr) & (bus.rs1_addr != 5'd0);
    assign bus.rs2_fwd_hit = vld_pipe[1] & (waddr_q == bus.rs2_addr) & (bus.rs2_addr != 5'd0);
    assign bus.fwd_data    = wdata_q;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus queues expected writes, a negedge monitor checks them.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    rf_wb_if #(.XLEN(32)) bus ();

    rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Every register-file write must match the oldest expected write.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.rf_waddr), 64'(e[36:32]));
                    check("wr_data", 64'(bus.rf_wdata), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.mem_valid = v; bus.mem_rd = rd; bus.mem_data = d;
    endtask

    initial begin
        set_alu(1'b1, 5'd1, 32'h1);
        set_mem(1'b0, 5'd0, 32'h0);
`ifdef RF_WB_ARB_BYPASS_EN
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
`endif
        #2;
        check("rst_we",        64'(bus.rf_we),     64'd0);
        check("rst_waddr",     64'(bus.rf_waddr),  64'd0);
        check("rst_wdata",     64'(bus.rf_wdata),  64'd0);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("rst_alu_prio",  64'(bus.alu_prio),  64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_alu(1'b0, 5'd0, 32'h0);

        // single ALU write
        @(negedge clk);
        set_alu(1'b1, 5'd5, 32'h1234);
        #1 check("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        push(5'd5, 32'h1234);
        @(negedge clk);
        set_alu(1'b0, 5'd0, 32'h0);
        #1 check("t1_we_high", 64'(bus.rf_we), 64'd1);
        @(negedge clk);
        #1 check("t1_we_low", 64'(bus.rf_we), 64'd0);

        // simultaneous requests, load first
        @(negedge clk);
        set_mem(1'b1, 5'd3, 32'hAAAA);
        set_alu(1'b1, 5'd4, 32'hBBBB);
        #1 check("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("t2_alu_ready", 64'(bus.alu_ready), 64'd0);
        push(5'd3, 32'hAAAA);
        @(negedge clk);
        set_mem(1'b0, 5'd0, 32'h0);
        #1 check("t2_alu_ready2", 64'(bus.alu_ready), 64'd1);
        push(5'd4, 32'hBBBB);
        @(negedge clk);
        set_alu(1'b0, 5'd0, 32'h0);

        // starvation: four load grants, then the ALU is forced through
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_mem(1'b1, 5'(10 + i), 32'h100 + 32'(i));
            set_alu(1'b1, 5'd20, 32'hC0DE);
            #1 check("t3_mem_ready", 64'(bus.mem_ready), 64'd1);
            check("t3_alu_ready", 64'(bus.alu_ready), 64'd0);
            check("t3_prio_low",  64'(bus.alu_prio),  64'd0);
            push(5'(10 + i), 32'h100 + 32'(i));
        end
        @(negedge clk);
        set_mem(1'b1, 5'd14, 32'h114);
        #1 check("t3_prio_high",  64'(bus.alu_prio),  64'd1);
        check("t3_alu_forced", 64'(bus.alu_ready), 64'd1);
        check("t3_mem_held",   64'(bus.mem_ready), 64'd0);
        push(5'd20, 32'hC0DE);
        @(negedge clk);
        set_alu(1'b0, 5'd0, 32'h0);
        #1 check("t3_prio_back", 64'(bus.alu_prio),  64'd0);
        check("t3_mem_again", 64'(bus.mem_ready), 64'd1);
        push(5'd14, 32'h114);

        // x0 write is accepted and dropped
        @(negedge clk);
        set_mem(1'b1, 5'd0, 32'hFFFF);
        #1 check("t4_mem_ready", 64'(bus.mem_ready), 64'd1);
        @(negedge clk);
        set_mem(1'b0, 5'd0, 32'h0);
        #1 check("t4_we",    64'(bus.rf_we),    64'd0);
        check("t4_waddr", 64'(bus.rf_waddr), 64'd14);
        check("t4_wdata", 64'(bus.rf_wdata), 64'h114);

        // asynchronous reset discards the registered x7 write and the PRI_ALU state
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            set_mem(1'b1, (j == 3) ? 5'd7 : 5'(11 + j), 32'h700 + 32'(j));
            set_alu(1'b1, 5'd21, 32'hD00D);
            #1 check("t5_mem_ready", 64'(bus.mem_ready), 64'd1);
            if (j < 3) push(5'(11 + j), 32'h700 + 32'(j));
        end
        @(posedge clk);
        #1 check("t5_we_before", 64'(bus.rf_we), 64'd1);
        #1 rst = 1'b1;
        #1 check("t5_we_async",  64'(bus.rf_we),     64'd0);
        check("t5_prio_async", 64'(bus.alu_prio),  64'd0);
        check("t5_mem_rdy",    64'(bus.mem_ready), 64'd0);
        check("t5_alu_rdy",    64'(bus.alu_ready), 64'd0);
        check("t5_waddr",      64'(bus.rf_waddr),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            set_mem(1'b1, 5'(15 + k), 32'h800 + 32'(k));
            #1 check("t5_post_mem", 64'(bus.mem_ready), 64'd1);
            check("t5_post_prio", 64'(bus.alu_prio), 64'd0);
            push(5'(15 + k), 32'h800 + 32'(k));
        end
        @(negedge clk);
        #1 check("t5_post_prio_hi", 64'(bus.alu_prio),  64'd1);
        check("t5_post_alu",     64'(bus.alu_ready), 64'd1);
        push(5'd21, 32'hD00D);
        @(negedge clk);
        set_alu(1'b0, 5'd0, 32'h0);
        set_mem(1'b0, 5'd0, 32'h0);

`ifdef RF_WB_ARB_BYPASS_EN
        @(negedge clk);
        set_alu(1'b1, 5'd9, 32'h55);
        push(5'd9, 32'h55);
        @(negedge clk);
        set_alu(1'b0, 5'd0, 32'h0);
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd0;
        #1 check("byp_rs1_hit", 64'(bus.rs1_fwd_hit), 64'd1);
        check("byp_rs2_hit", 64'(bus.rs2_fwd_hit), 64'd0);
        check("byp_data",    64'(bus.fwd_data),    64'h55);
        @(negedge clk);
        #1 check("byp_rs1_idle", 64'(bus.rs1_fwd_hit), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback sources: the ALU result path and the data-memory load path.
- Registers the winning write for one cycle, then drives the register file's write-enable, destination address and write data.
- Fixed priority goes to loads. A starvation counter forces an ALU grant after a bounded number of lost cycles.
- Sits between the execute/memory stages and the register file and replaces the old mem_to_reg result mux.

Parameters:
- XLEN, 32, data width of the write port.
- STARVE_LIMIT, 4, consecutive lost ALU cycles before the ALU gets priority; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_rd  in  5  load destination register
- mem_data  in  XLEN  load data
- mem_ready  out  1  load request accepted this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- alu_prio  out  1  high while in state PRI_ALU (debug and verification visibility)

Behaviour:
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, state=PRI_MEM, starve_cnt=0. alu_ready and mem_ready are 0 while rst is high.
- Reset is asynchronous and takes effect immediately. A write that is registered but not yet committed is discarded.
- States:
  - PRI_MEM: mem_valid wins; otherwise alu_valid wins.
  - PRI_ALU: alu_valid wins; otherwise mem_valid wins.
- Grant is combinational. ready = valid & granted. A source transfers on valid & ready at the clock edge.
- At most one ready is high per cycle. Sources must hold valid, rd and data stable until ready.
- starve_cnt, 4 bits:
  - increments when alu_valid=1 and mem was granted;
  - clears when the ALU is granted or alu_valid=0;
  - saturates at STARVE_LIMIT.
- State transitions:
  - PRI_MEM -> PRI_ALU at the edge where starve_cnt reaches STARVE_LIMIT.
  - PRI_ALU -> PRI_MEM at the edge of the ALU grant; starve_cnt clears on the same edge.
  - PRI_ALU with alu_valid=0 returns to PRI_MEM.
- Output stage: on a transfer, the next edge sets rf_we=1, rf_waddr=rd and rf_wdata=data. With no transfer, rf_we=0 and addr/data hold their values.
- Latency is 1 cycle from handshake to rf_we. The register file commits on the following edge.
- rd==0: the request is accepted (ready=1) but rf_we stays 0. Data is dropped and addr/data are not updated.
- The register file never back-pressures. A transfer can occur every cycle, giving 1 write per cycle throughput.
- Both requesters targeting the same rd in consecutive cycles: both writes issue in grant order, so the last grant wins in the register file.

Optional Feature:
- Macro: RF_WB_ARB_BYPASS_EN.
- When defined, add these ports:
  - rs1_addr in 5, rs2_addr in 5;
  - rs1_fwd_hit out 1, rs2_fwd_hit out 1, fwd_data out XLEN.
- hit = rf_we & (rf_waddr == rsN_addr) & (rsN_addr != 0), computed combinationally.
- fwd_data = rf_wdata.
- The decode stage uses these to see a write registered this cycle before the register file commits it.
- When not defined, the ports are absent and there is no extra logic.

Test Plan:
- Reset then single ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 -> alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; following cycle rf_we=0.
- Simultaneous requests in PRI_MEM: mem_rd=3/0xAAAA, alu_rd=4/0xBBBB -> mem_ready=1, alu_ready=0; next cycle writes x3=0xAAAA; cycle after grants ALU and writes x4=0xBBBB.
- Starvation, STARVE_LIMIT=4: mem_valid and alu_valid held high -> mem granted 4 cycles, starve_cnt 1..4, alu_prio=1, 5th cycle grants ALU, then back to PRI_MEM with starve_cnt=0.
- Writes to x0: mem_valid=1, mem_rd=0, mem_data=0xFFFF -> mem_ready=1; next cycle rf_we=0 and rf_waddr/rf_wdata unchanged.
- Reset mid-operation: assert rst asynchronously the cycle after a grant for x7 -> rf_we drops to 0 without waiting for an edge, x7 is not written, and the state returns to PRI_MEM with starve_cnt=0.
- With RF_WB_ARB_BYPASS_EN, ALU write to x9=0x55 then rs1_addr=9, rs2_addr=0 during the rf_we cycle -> rs1_fwd_hit=1, fwd_data=0x55, rs2_fwd_hit=0.
